uart_baud_gen: RTL

Parametrised UART baud-rate tick generator, the successor to the fixed-rate 16x baud divider. It adds a runtime-loadable integer+fractional divisor, a configurable oversampling factor, and separate oversample, bit and mid-bit strobes. A resync input lets the receiver phase-align to a detected start edge. It sits between the system clock domain and the UART TX/RX engines and drives all of their timing.

---
 rtl/uart_baud_gen.sv | 118 +++++++++++
 1 files changed

// File: rtl/uart_baud_gen.sv
// UART baud tick generator: integer+fractional divisor, oversample/bit/mid strobes.
// Optional BAUD_CLK_OUT_EN adds a registered bit-rate square wave on baud_clk.
module uart_baud_gen #(
    parameter int OVERSAMPLE   = 16,
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int RST_DIV_INT  = 325,
    parameter int RST_DIV_FRAC = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              resync,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    output logic              div_pending,
    output logic              os_tick,
    output logic              bit_tick,
    output logic              mid_tick
`ifdef BAUD_CLK_OUT_EN
    ,
    output logic              baud_clk
`endif
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [DIV_W-1:0] RST_INT = DIV_W'(RST_DIV_INT);
    localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(RST_DIV_FRAC);

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(2)) ? DIV_W'(2) : d;
    endfunction

    logic [DIV_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;
    logic              cry;
    logic [OS_W-1:0]   os_cnt;
    logic [DIV_W-1:0]  act_int;
    logic [FRAC_W-1:0] act_frac;
    logic [DIV_W-1:0]  sh_int;
    logic [FRAC_W-1:0] sh_frac;

    logic [DIV_W:0]    per_last;
    logic [FRAC_W:0]   frac_sum;
    logic              wrap;
    logic              apply;

    // Last count of the current period: active divisor stretched by the carry.
    assign per_last = {1'b0, act_int} + (DIV_W+1)'(cry) - (DIV_W+1)'(1);
    assign frac_sum = {1'b0, acc} + {1'b0, act_frac};
    assign wrap     = en && !resync && ({1'b0, cnt} == per_last);
    assign apply    = div_pending && (wrap || !en || resync);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            acc         <= '0;
            cry         <= 1'b0;
            os_cnt      <= '0;
            act_int     <= clamp_div(RST_INT);
            act_frac    <= RST_FRAC;
            sh_int      <= RST_INT;
            sh_frac     <= RST_FRAC;
            div_pending <= 1'b0;
            os_tick     <= 1'b0;
            bit_tick    <= 1'b0;
            mid_tick    <= 1'b0;
        end else begin
            os_tick  <= wrap;
            bit_tick <= wrap && (os_cnt == OS_LAST);
            mid_tick <= wrap && (os_cnt == OS_MID);
            if (resync) begin
                cnt    <= '0;
                acc    <= '0;
                cry    <= 1'b0;
                os_cnt <= '0;
            end else if (en) begin
                if (wrap) begin
                    cnt        <= '0;
                    {cry, acc} <= frac_sum;
                    os_cnt     <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (apply) begin
                act_int  <= clamp_div(sh_int);
                act_frac <= sh_frac;
            end
            // A fresh load always re-arms the shadow, even on an apply edge.
            if (div_load) begin
                sh_int      <= div_int;
                sh_frac     <= div_frac;
                div_pending <= 1'b1;
            end else if (apply) begin
                div_pending <= 1'b0;
            end
        end
    end

`ifdef BAUD_CLK_OUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            baud_clk <= 1'b0;
        end else if (resync) begin
            baud_clk <= 1'b0;
        end else if (wrap && (os_cnt == OS_MID)) begin
            baud_clk <= 1'b1;
        end else if (wrap && (os_cnt == OS_LAST)) begin
            baud_clk <= 1'b0;
        end
    end
`endif

endmodule
